// File: rtl/pipe_ctrl_if.sv
// Control bundle between the riscx stage registers and pipe_ctrl.
// All inputs are level-sampled every cycle, with no valid/ready handshake. The core (master) holds them stable around the rising edge. pipe_ctrl (slave) returns stall/flush combinationally and vld/counters registered.
interface pipe_ctrl_if #(
    parameter int NSTAGE        = 5,
    parameter int PC_WIDTH      = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int CNT_WIDTH     = 32
);
    logic                     if_vld_i;
    logic                     id_rs1_en_i;
    logic                     id_rs2_en_i;
    logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i;
    logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i;
    logic                     ex_rd_en_i;
    logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i;
    logic                     ex_is_load_i;
    logic                     mem_busy_i;
    logic                     flush_req_i;
    logic [PC_WIDTH-1:0]      flush_pc_i;
    logic                     cnt_clr_i;
    logic [NSTAGE-1:0]        vld_o;
    logic [NSTAGE-1:0]        stall_o;
    logic                     flush_o;
    logic [PC_WIDTH-1:0]      flush_pc_o;
    logic [CNT_WIDTH-1:0]     stall_cnt_o;
    logic [CNT_WIDTH-1:0]     flush_cnt_o;
    logic                     mem_timeout_o;

    modport master (
        output if_vld_i, id_rs1_en_i, id_rs2_en_i, id_rs1_idx_i, id_rs2_idx_i,
               ex_rd_en_i, ex_rd_idx_i, ex_is_load_i, mem_busy_i,
               flush_req_i, flush_pc_i, cnt_clr_i,
        input  vld_o, stall_o, flush_o, flush_pc_o, stall_cnt_o, flush_cnt_o,
               mem_timeout_o
    );

    modport slave (
        input  if_vld_i, id_rs1_en_i, id_rs2_en_i, id_rs1_idx_i, id_rs2_idx_i,
               ex_rd_en_i, ex_rd_idx_i, ex_is_load_i, mem_busy_i,
               flush_req_i, flush_pc_i, cnt_clr_i,
        output vld_o, stall_o, flush_o, flush_pc_o, stall_cnt_o, flush_cnt_o,
               mem_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control for the riscx in-order core: per-stage valid tracking,
// load-use / memory-stall hold and bubble control, EX flush gating, counters and watchdog.
module pipe_ctrl #(
    parameter int NSTAGE        = 5,
    parameter int ID_STG        = 1,
    parameter int EX_STG        = 2,
    parameter int MEM_STG       = 3,
    parameter int PC_WIDTH      = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int CNT_WIDTH     = 32,
    parameter int MEM_TIMEOUT   = 64
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(MEM_TIMEOUT);

    logic [NSTAGE-1:0]        vld_q, vld_d;
    logic [NSTAGE-1:0]        stall;
    logic                     flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]     flush_cnt_q, flush_cnt_d;
    logic [BUSY_W-1:0]        busy_cnt_q, busy_cnt_d;
    logic                     timeout_q, timeout_d;
    logic                     lu, ms, fl, rs_match;
    logic [REG_IDX_WIDTH-1:0] rd_idx;
    logic [PC_WIDTH-1:0]      flush_pc;

    assign rd_idx   = bus.ex_rd_idx_i;
    assign flush_pc = bus.flush_pc_i;

    // Hazard detection and stall mask; a memory stall outranks load-use.
    always_comb begin
        rs_match = (bus.id_rs1_en_i && (bus.id_rs1_idx_i == rd_idx)) ||
                   (bus.id_rs2_en_i && (bus.id_rs2_idx_i == rd_idx));
        lu = vld_q[ID_STG] && vld_q[EX_STG] && bus.ex_is_load_i &&
             bus.ex_rd_en_i && (rd_idx != '0) && rs_match;
        ms = vld_q[MEM_STG] && bus.mem_busy_i;
        fl = bus.flush_req_i && vld_q[EX_STG] && !flush_done_q;
        stall = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (ms && (i <= MEM_STG)) begin
                stall[i] = 1'b1;
            end else if (lu && (i <= ID_STG)) begin
                stall[i] = 1'b1;
            end
        end
    end

    // Held stages keep their bit, the first unheld stage receives a bubble,
    // and a flush squashes everything younger than EX.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = stall[0] ? vld_q[0] : bus.if_vld_i;
        for (int i = 1; i < NSTAGE; i++) begin
            if (stall[i]) begin
                vld_d[i] = vld_q[i];
            end else if (stall[i-1]) begin
                vld_d[i] = 1'b0;
            end else begin
                vld_d[i] = vld_q[i-1];
            end
        end
        if (fl) begin
            for (int i = 0; i < EX_STG; i++) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        flush_done_d = flush_done_q;
        if (!stall[EX_STG]) begin
            flush_done_d = 1'b0;
        end else if (fl) begin
            flush_done_d = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((|stall) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (fl && (flush_cnt_q != '1))       flush_cnt_d = flush_cnt_q + 1'b1;
        end

        busy_cnt_d = '0;
        if (ms) begin
            busy_cnt_d = (busy_cnt_q == BUSY_MAX) ? busy_cnt_q : busy_cnt_q + 1'b1;
        end
        timeout_d = timeout_q || (busy_cnt_d == BUSY_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            flush_done_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            busy_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            flush_done_q <= flush_done_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.vld_o         = vld_q;
    assign bus.stall_o       = stall;
    assign bus.flush_o       = fl;
    assign bus.flush_pc_o    = flush_pc;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.mem_timeout_o = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run, all checked
// against a mask-arithmetic reference model of the pipeline.
module tb_pipe_ctrl;
    localparam int NS  = 5;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int TO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.NSTAGE(NS), .PC_WIDTH(32), .REG_IDX_WIDTH(5), .CNT_WIDTH(32)) bus ();

    pipe_ctrl #(
        .NSTAGE(NS), .ID_STG(ID), .EX_STG(EX), .MEM_STG(MEM), .PC_WIDTH(32),
        .REG_IDX_WIDTH(5), .CNT_WIDTH(32), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model state.
    logic [NS-1:0] m_vld;
    logic          m_fdone;
    logic [31:0]   m_scnt, m_fcnt;
    int            m_busy;
    logic          m_to;
    logic [NS-1:0] e_stall;
    logic          e_flush, e_ms;

    function automatic void model_comb();
        logic lu;
        int   top;
        lu = m_vld[ID] && m_vld[EX] && bus.ex_is_load_i && bus.ex_rd_en_i &&
             (bus.ex_rd_idx_i != 0) &&
             ((bus.id_rs1_en_i && bus.id_rs1_idx_i == bus.ex_rd_idx_i) ||
              (bus.id_rs2_en_i && bus.id_rs2_idx_i == bus.ex_rd_idx_i));
        e_ms    = m_vld[MEM] && bus.mem_busy_i;
        top     = e_ms ? MEM : (lu ? ID : -1);
        e_stall = NS'((1 << (top + 1)) - 1);
        e_flush = bus.flush_req_i && m_vld[EX] && !m_fdone;
    endfunction

    function automatic void model_seq();
        logic [NS-1:0] shifted, keep, bub, nv;
        if (rst) begin
            m_vld = '0; m_fdone = 1'b0; m_scnt = '0; m_fcnt = '0; m_busy = 0; m_to = 1'b0;
            return;
        end
        model_comb();
        shifted = {m_vld[NS-2:0], bus.if_vld_i};
        keep    = e_stall;
        bub     = keep << 1;
        nv      = (m_vld & keep) | (shifted & ~keep & ~bub);
        if (e_flush) nv = nv & ~NS'((1 << EX) - 1);
        if (!e_stall[EX]) m_fdone = 1'b0;
        else if (e_flush) m_fdone = 1'b1;
        if (bus.cnt_clr_i) begin
            m_scnt = '0;
            m_fcnt = '0;
        end else begin
            if (e_stall != 0 && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (e_flush && m_fcnt != 32'hFFFF_FFFF)      m_fcnt = m_fcnt + 1;
        end
        if (e_ms) begin
            m_busy++;
            if (m_busy >= TO) m_to = 1'b1;
        end else begin
            m_busy = 0;
        end
        m_vld = nv;
    endfunction

    // Drivers
    task automatic tick();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic drive_idle();
        bus.if_vld_i = 0; bus.id_rs1_en_i = 0; bus.id_rs2_en_i = 0;
        bus.id_rs1_idx_i = 0; bus.id_rs2_idx_i = 0; bus.ex_rd_en_i = 0;
        bus.ex_rd_idx_i = 0; bus.ex_is_load_i = 0; bus.mem_busy_i = 0;
        bus.flush_req_i = 0; bus.flush_pc_i = 0; bus.cnt_clr_i = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill();
        bus.if_vld_i = 1'b1;
        repeat (NS) tick();
    endtask

    task automatic drive_lu(input logic [4:0] rd);
        bus.id_rs1_en_i = 1; bus.id_rs1_idx_i = 5'd5;
        bus.ex_is_load_i = 1; bus.ex_rd_en_i = 1; bus.ex_rd_idx_i = rd;
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++; if (bus.vld_o !== 5'b0) $display("FAIL reset_vld: got %b want 0", bus.vld_o); else n_pass++;
        n_total++; if (bus.stall_o !== 5'b0) $display("FAIL reset_stall: got %b want 0", bus.stall_o); else n_pass++;
        n_total++; if (bus.flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush_o); else n_pass++;
        n_total++; if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt_o, bus.flush_cnt_o); else n_pass++;
        n_total++; if (bus.mem_timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.mem_timeout_o); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        fill();
        drive_lu(5'd5);
        @(negedge clk);
        n_total++; if (bus.stall_o !== 5'b00011) $display("FAIL lu_stall: got %b want 00011", bus.stall_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (bus.stall_o !== 5'b0) $display("FAIL lu_release: got %b want 0", bus.stall_o); else n_pass++;
        n_total++; if (bus.vld_o !== 5'b11011) $display("FAIL lu_bubble: got %b want 11011", bus.vld_o); else n_pass++;
        n_total++; if (bus.stall_cnt_o !== 32'd1) $display("FAIL lu_cnt: got %0d want 1", bus.stall_cnt_o); else n_pass++;
        drive_idle();
    endtask

    task automatic test_load_x0();
        do_reset();
        fill();
        drive_lu(5'd0);
        bus.id_rs1_idx_i = 5'd0;
        @(negedge clk);
        n_total++; if (bus.stall_o !== 5'b0) $display("FAIL x0_stall: got %b want 0", bus.stall_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (bus.vld_o !== 5'b11111) $display("FAIL x0_vld: got %b want 11111", bus.vld_o); else n_pass++;
        n_total++; if (bus.stall_cnt_o !== 32'd0) $display("FAIL x0_cnt: got %0d want 0", bus.stall_cnt_o); else n_pass++;
        drive_idle();
    endtask

    task automatic test_mem_stall();
        do_reset();
        fill();
        bus.mem_busy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_total++; if (bus.vld_o[4] !== 1'b0) $display("FAIL ms_bubble%0d: got %b want 0", k, bus.vld_o[4]); else n_pass++;
            end
            n_total++; if (bus.stall_o !== 5'b01111) $display("FAIL ms_stall%0d: got %b want 01111", k, bus.stall_o); else n_pass++;
            tick();
        end
        bus.mem_busy_i = 1'b0;
        @(negedge clk);
        n_total++; if (bus.vld_o[4] !== 1'b0) $display("FAIL ms_bubble3: got %b want 0", bus.vld_o[4]); else n_pass++;
        n_total++; if (bus.stall_o !== 5'b0) $display("FAIL ms_release: got %b want 0", bus.stall_o); else n_pass++;
        n_total++; if (bus.stall_cnt_o !== 32'd3) $display("FAIL ms_cnt: got %0d want 3", bus.stall_cnt_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (bus.vld_o[4] !== 1'b1) $display("FAIL ms_drain: got %b want 1", bus.vld_o[4]); else n_pass++;
        drive_idle();
    endtask

    task automatic test_flush_lu();
        logic [31:0] pc;
        do_reset();
        fill();
        pc = $urandom();
        drive_lu(5'd5);
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = pc;
        @(negedge clk);
        n_total++; if (bus.flush_o !== 1'b1) $display("FAIL fl_lu_flush: got %b want 1", bus.flush_o); else n_pass++;
        n_total++; if (bus.flush_pc_o !== pc) $display("FAIL fl_lu_pc: got %h want %h", bus.flush_pc_o, pc); else n_pass++;
        n_total++; if (bus.stall_o !== 5'b00011) $display("FAIL fl_lu_stall: got %b want 00011", bus.stall_o); else n_pass++;
        tick();
        drive_idle();
        bus.if_vld_i = 1'b1;
        @(negedge clk);
        n_total++; if (bus.vld_o !== 5'b11000) $display("FAIL fl_lu_vld: got %b want 11000", bus.vld_o); else n_pass++;
        n_total++; if (bus.flush_cnt_o !== 32'd1) $display("FAIL fl_lu_cnt: got %0d want 1", bus.flush_cnt_o); else n_pass++;
        drive_idle();
    endtask

    task automatic test_flush_ms();
        int nfl;
        nfl = 0;
        do_reset();
        fill();
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = 32'h0000_1000;
        for (int k = 0; k < 4; k++) begin
            bus.mem_busy_i = (k < 3);
            @(negedge clk);
            if (bus.flush_o === 1'b1) nfl++;
            n_total++; if (bus.flush_o !== (k == 0)) $display("FAIL fl_ms_cyc%0d: got %b want %b", k, bus.flush_o, (k == 0)); else n_pass++;
            tick();
        end
        drive_idle();
        @(negedge clk);
        n_total++; if (nfl !== 1) $display("FAIL fl_ms_once: got %0d want 1", nfl); else n_pass++;
        n_total++; if (bus.flush_cnt_o !== 32'd1) $display("FAIL fl_ms_cnt: got %0d want 1", bus.flush_cnt_o); else n_pass++;
    endtask

    task automatic test_watchdog();
        do_reset();
        fill();
        bus.mem_busy_i = 1'b1;
        repeat (TO - 1) tick();
        @(negedge clk);
        n_total++; if (bus.mem_timeout_o !== 1'b0) $display("FAIL wd_early: got %b want 0", bus.mem_timeout_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (bus.mem_timeout_o !== 1'b1) $display("FAIL wd_fire: got %b want 1", bus.mem_timeout_o); else n_pass++;
        bus.mem_busy_i = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        n_total++; if (bus.mem_timeout_o !== 1'b1) $display("FAIL wd_sticky: got %b want 1", bus.mem_timeout_o); else n_pass++;
        n_total++; if (bus.stall_cnt_o !== 32'd64) $display("FAIL wd_cnt: got %0d want 64", bus.stall_cnt_o); else n_pass++;
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        @(negedge clk);
        n_total++; if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0)
            $display("FAIL wd_clr: got %0d/%0d want 0/0", bus.stall_cnt_o, bus.flush_cnt_o); else n_pass++;
        n_total++; if (bus.mem_timeout_o !== 1'b1) $display("FAIL wd_clr_keep: got %b want 1", bus.mem_timeout_o); else n_pass++;
        // Reset in the middle of a stall with a flush pending.
        bus.mem_busy_i = 1'b1; bus.flush_req_i = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.vld_o !== 5'b0 || bus.stall_o !== 5'b0 || bus.flush_o !== 1'b0)
            $display("FAIL wd_rst_pipe: got vld=%b stall=%b flush=%b want 0", bus.vld_o, bus.stall_o, bus.flush_o); else n_pass++;
        n_total++; if (bus.mem_timeout_o !== 1'b0 || bus.stall_cnt_o !== 32'd0)
            $display("FAIL wd_rst_state: got to=%b cnt=%0d want 0", bus.mem_timeout_o, bus.stall_cnt_o); else n_pass++;
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.if_vld_i     = ($urandom_range(0, 9) < 8);
            bus.id_rs1_en_i  = $urandom_range(0, 1);
            bus.id_rs2_en_i  = $urandom_range(0, 1);
            bus.id_rs1_idx_i = 5'($urandom_range(0, 3));
            bus.id_rs2_idx_i = 5'($urandom_range(0, 3));
            bus.ex_rd_en_i   = ($urandom_range(0, 3) != 0);
            bus.ex_rd_idx_i  = 5'($urandom_range(0, 3));
            bus.ex_is_load_i = $urandom_range(0, 1);
            bus.mem_busy_i   = ($urandom_range(0, 9) < 4);
            bus.flush_req_i  = ($urandom_range(0, 9) < 2);
            bus.flush_pc_i   = $urandom();
            bus.cnt_clr_i    = ($urandom_range(0, 49) == 0);
            rst              = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            model_comb();
            n_total++; if (bus.vld_o !== m_vld) $display("FAIL rnd_vld@%0d: got %b want %b", c, bus.vld_o, m_vld); else n_pass++;
            n_total++; if (bus.stall_o !== e_stall) $display("FAIL rnd_stall@%0d: got %b want %b", c, bus.stall_o, e_stall); else n_pass++;
            n_total++; if (bus.flush_o !== e_flush) $display("FAIL rnd_flush@%0d: got %b want %b", c, bus.flush_o, e_flush); else n_pass++;
            n_total++; if (bus.flush_pc_o !== bus.flush_pc_i) $display("FAIL rnd_pc@%0d: got %h want %h", c, bus.flush_pc_o, bus.flush_pc_i); else n_pass++;
            n_total++; if (bus.stall_cnt_o !== m_scnt || bus.flush_cnt_o !== m_fcnt)
                $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", c, bus.stall_cnt_o, bus.flush_cnt_o, m_scnt, m_fcnt); else n_pass++;
            n_total++; if (bus.mem_timeout_o !== m_to) $display("FAIL rnd_to@%0d: got %b want %b", c, bus.mem_timeout_o, m_to); else n_pass++;
            tick();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL time_limit: simulation did not finish within bound");
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_load_use();
        test_load_x0();
        test_mem_stall();
        test_flush_lu();
        test_flush_ms();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
